// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: default widths, reset PC, control FSM states
// and the {pc, instr} queue entry layout.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = '0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_REDIR = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic circular FIFO with head peek and flush; 1-cycle write-to-read latency.
// Push is refused only when full and not popping in the same cycle; flush wins over push/pop.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues in-order imem requests under a credit limit and buffers {pc, instr}.
// Response to instr_valid is 1 cycle; decode backpressure throttles requests, redirect flushes and discards.
module fetch_queue #(
    parameter int              XLEN      = fetch_pkg::XLEN,
    parameter int              DEPTH     = 4,
    parameter int              MAX_OUTST = 4,
    parameter logic [XLEN-1:0] RESET_PC  = fetch_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_select_execute,
    input  logic [XLEN-1:0] pc_target_execute,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instruction_fetch,
    output logic [XLEN-1:0] pc_fetch,
    output logic [XLEN-1:0] next_pc_fetch
);

    import fetch_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTST + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [OW-1:0]   discard_q, discard_d;
    logic            redirect, req_fire, rsp_live, rsp_drop;
    entry_t          q_push_dat, q_head;
    logic            q_full, q_empty, trk_full, trk_empty;
    logic [CW-1:0]   q_count;
    logic [OW-1:0]   trk_count;
    logic [XLEN-1:0] trk_head;
    int              outst;

    // Stale (discarded) requests still occupy queue credit until their responses drain.
    assign redirect       = pc_select_execute;
    assign outst          = int'(trk_count) + int'(discard_q);
    assign imem_req_valid = !rst && !redirect && (state_q != ST_REDIR) && !q_full && !trk_full
                            && (int'(q_count) + outst < DEPTH) && (outst < MAX_OUTST);
    assign imem_req_addr  = req_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop   = imem_rsp_valid && (discard_q != '0);
    assign rsp_live   = imem_rsp_valid && (discard_q == '0) && !trk_empty;
    assign q_push_dat = '{pc: trk_head, instr: imem_rsp_data};

    assign instr_valid       = !q_empty && !redirect;
    assign instruction_fetch = instr_valid ? q_head.instr : '0;
    assign pc_fetch          = instr_valid ? q_head.pc : '0;
    assign next_pc_fetch     = instr_valid ? q_head.pc + XLEN'(4) : '0;

    always_comb begin
        req_pc_d  = req_pc_q;
        discard_d = discard_q;
        state_d   = state_q;
        if (redirect) begin
            req_pc_d  = pc_target_execute & ~XLEN'(3);
            discard_d = OW'(outst - (((imem_rsp_valid) && (outst != 0)) ? 1 : 0));
            state_d   = ST_REDIR;
        end else begin
            if (req_fire) begin
                req_pc_d = req_pc_q + XLEN'(4);
            end
            if (rsp_drop) begin
                discard_d = discard_q - 1'b1;
            end
            case (state_q)
                ST_REDIR: state_d = (discard_d != '0) ? ST_DRAIN : ST_RUN;
                ST_DRAIN: state_d = (discard_d == '0) ? ST_RUN : ST_DRAIN;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            req_pc_q  <= RESET_PC;
            discard_q <= '0;
        end else begin
            state_q   <= state_d;
            req_pc_q  <= req_pc_d;
            discard_q <= discard_d;
        end
    end

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_data_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rsp_live),
        .push_dat (q_push_dat),
        .pop      (instr_valid && instr_ready),
        .flush    (redirect),
        .head_dat (q_head),
        .full     (q_full),
        .empty    (q_empty),
        .count    (q_count)
    );

    // PCs of live outstanding requests, consumed in response order.
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTST)
    ) u_pc_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (req_fire),
        .push_dat (req_pc_q),
        .pop      (rsp_live),
        .flush    (redirect),
        .head_dat (trk_head),
        .full     (trk_full),
        .empty    (trk_empty),
        .count    (trk_count)
    );

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && (discard_q == '0) && trk_empty));

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: an in-bench memory and expected-instruction-stream model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int          DEPTH     = 4;
    localparam int          MAX_OUTST = 4;
    localparam logic [31:0] RST_PC    = 32'h0;

    logic        clk, rst;
    logic        pc_select_execute;
    logic [31:0] pc_target_execute;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instruction_fetch, pc_fetch, next_pc_fetch;

    fetch_queue #(
        .XLEN(32), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RST_PC)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .pc_select_execute (pc_select_execute),
        .pc_target_execute (pc_target_execute),
        .imem_req_valid    (imem_req_valid),
        .imem_req_ready    (imem_req_ready),
        .imem_req_addr     (imem_req_addr),
        .imem_rsp_valid    (imem_rsp_valid),
        .imem_rsp_data     (imem_rsp_data),
        .instr_valid       (instr_valid),
        .instr_ready       (instr_ready),
        .instruction_fetch (instruction_fetch),
        .pc_fetch          (pc_fetch),
        .next_pc_fetch     (next_pc_fetch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t         pend[$];
    fetch_entry_t exp_q[$];
    int           cyc, epoch, last_due, drops;
    logic [31:0]  m_req_pc;
    bit           redir_prev;
    int           n_cmp, n_bad;

    int          k_req, k_dec, k_redir, k_lat_min, k_lat_max;
    bit          f_redir, f_redir_on_rsp_pop, fired;
    logic [31:0] f_target;

    logic        s_ivld, s_rvld;
    logic [31:0] s_raddr, s_pc, s_npc, s_ins;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        bit          rsp, redir, rrdy, irdy, exp_ivld, exp_rvld;
        logic [31:0] tgt;
        req_t        r;
        int          due;
        rsp = 1'b0;
        if (pend.size() > 0) rsp = (pend[0].due <= cyc);
        rrdy  = ($urandom_range(99) < k_req);
        irdy  = ($urandom_range(99) < k_dec);
        redir = f_redir || ($urandom_range(999) < k_redir);
        if (f_redir) tgt = f_target;
        else if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 + $urandom_range(15);
        else tgt = $urandom_range(1023);
        if (f_redir_on_rsp_pop && rsp && irdy && exp_q.size() > 0) begin
            redir = 1'b1;
            fired = 1'b1;
            f_redir_on_rsp_pop = 1'b0;
        end
        f_redir = 1'b0;

        imem_rsp_valid    = rsp;
        imem_rsp_data     = rsp ? instr_of(pend[0].addr) : $urandom;
        imem_req_ready    = rrdy;
        instr_ready       = irdy;
        pc_select_execute = redir;
        pc_target_execute = tgt;

        @(negedge clk);
        s_ivld  = instr_valid;
        s_rvld  = imem_req_valid;
        s_raddr = imem_req_addr;
        s_pc    = pc_fetch;
        s_npc   = next_pc_fetch;
        s_ins   = instruction_fetch;

        exp_ivld = (exp_q.size() > 0) && !redir;
        exp_rvld = !redir && !redir_prev && (exp_q.size() + pend.size() < DEPTH)
                   && (pend.size() < MAX_OUTST);
        chk("instr_valid", 32'(s_ivld), 32'(exp_ivld));
        if (exp_ivld) begin
            chk("pc_fetch", s_pc, exp_q[0].pc);
            chk("next_pc_fetch", s_npc, exp_q[0].pc + 32'd4);
            chk("instruction_fetch", s_ins, exp_q[0].instr);
        end
        chk("imem_req_valid", 32'(s_rvld), 32'(exp_rvld));
        if (exp_rvld) chk("imem_req_addr", s_raddr, m_req_pc);

        if (rsp) begin
            r = pend.pop_front();
            if (r.epoch != epoch) drops++;
        end
        if (redir) begin
            exp_q.delete();
            epoch++;
            m_req_pc = tgt & ~32'h3;
        end else begin
            if (exp_ivld && irdy) void'(exp_q.pop_front());
            if (rsp && r.epoch == epoch) exp_q.push_back('{pc: r.addr, instr: instr_of(r.addr)});
            if (exp_rvld && rrdy) begin
                due = cyc + int'($urandom_range(k_lat_max, k_lat_min));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend.push_back('{addr: m_req_pc, epoch: epoch, due: due});
                m_req_pc = m_req_pc + 32'd4;
            end
        end
        redir_prev = redir;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst               = 1'b1;
        pc_select_execute = 1'b0;
        imem_rsp_valid    = 1'b0;
        imem_req_ready    = 1'b0;
        instr_ready       = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instruction", instruction_fetch, 32'd0);
        chk("rst_pc_fetch", pc_fetch, 32'd0);
        chk("rst_next_pc", next_pc_fetch, 32'd0);
        chk("rst_req_addr", imem_req_addr, RST_PC);
        pend.delete();
        exp_q.delete();
        epoch++;
        m_req_pc   = RST_PC;
        redir_prev = 1'b0;
        last_due   = cyc;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_knobs(input int rq, input int dc, input int rd, input int lmin, input int lmax);
        k_req = rq; k_dec = dc; k_redir = rd; k_lat_min = lmin; k_lat_max = lmax;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        n_cmp = 0; n_bad = 0; cyc = 0; epoch = 0; drops = 0;
        f_redir = 0; f_redir_on_rsp_pop = 0; fired = 0; f_target = 0;
        pc_target_execute = 0; imem_rsp_data = 0;
        set_knobs(100, 100, 0, 1, 1);
        do_reset();

        // Streaming: first request immediately, then one instruction per cycle from PC 0.
        step();
        chk("first_req_valid", 32'(s_rvld), 32'd1);
        chk("first_req_addr", s_raddr, RST_PC);
        step();
        chk("stream_fill_valid", 32'(s_ivld), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stream_valid", 32'(s_ivld), 32'd1);
            chk("stream_pc", s_pc, 32'(4 * i));
        end

        // Decode backpressure fills the queue and stops requests.
        set_knobs(100, 0, 0, 1, 1);
        repeat (10) step();
        chk("bp_req_valid", 32'(s_rvld), 32'd0);
        chk("bp_instr_valid", 32'(s_ivld), 32'd1);
        chk("bp_model_count", 32'(exp_q.size()), 32'(DEPTH));
        set_knobs(100, 100, 0, 1, 1);
        repeat (10) step();

        // Redirect with three requests in flight.
        set_knobs(100, 100, 0, 5, 5);
        do_reset();
        repeat (3) step();
        chk("redir_outstanding", 32'(pend.size()), 32'd3);
        drops = 0; f_redir = 1; f_target = 32'h100;
        step();
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            found = s_ivld;
        end
        chk("redir_found", 32'(found), 32'd1);
        chk("redir_pc", s_pc, 32'h100);
        chk("redir_next_pc", s_npc, 32'h104);
        chk("redir_drops", 32'(drops), 32'd3);

        // Redirect coinciding with a response and a pop.
        set_knobs(100, 100, 0, 2, 2);
        fired = 0; f_redir_on_rsp_pop = 1;
        for (int i = 0; i < 60 && !fired; i++) step();
        f_redir_on_rsp_pop = 0;
        chk("coincide_fired", 32'(fired), 32'd1);
        step();
        chk("coincide_empty", 32'(s_ivld), 32'd0);
        repeat (10) step();

        // Misaligned target.
        f_redir = 1; f_target = 32'h203;
        step();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = s_rvld;
        end
        chk("misalign_found", 32'(found), 32'd1);
        chk("misalign_addr", s_raddr, 32'h200);

        // Address wrap at the top of the address space.
        f_redir = 1; f_target = 32'hFFFF_FFFC;
        step();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = s_ivld;
        end
        chk("wrap_pc", s_pc, 32'hFFFF_FFFC);
        chk("wrap_next_pc", s_npc, 32'h0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = s_ivld;
        end
        chk("wrap_following_pc", s_pc, 32'h0);

        // Reset mid-stream with two requests outstanding.
        set_knobs(100, 0, 0, 3, 3);
        do_reset();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = (pend.size() == 2) && (exp_q.size() > 0);
        end
        chk("midrst_setup", 32'(found), 32'd1);
        chk("midrst_pre_valid", 32'(s_ivld), 32'd1);
        do_reset();
        set_knobs(100, 100, 0, 1, 1);
        step();
        chk("midrst_first_req_valid", 32'(s_rvld), 32'd1);
        chk("midrst_first_req_addr", s_raddr, RST_PC);

        // Randomized traffic.
        for (int run = 0; run < 6; run++) begin
            int lmin;
            lmin = int'($urandom_range(2, 1));
            set_knobs(int'($urandom_range(100, 30)), int'($urandom_range(100, 20)),
                      int'($urandom_range(60)), lmin, int'($urandom_range(6, lmin)));
            if ($urandom_range(2) == 0) do_reset();
            repeat (500) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32: address and instruction width.
REQ-002 SHALL have parameter DEPTH, default 4: queue entries; power of two, at least 2.
REQ-003 SHALL have parameter MAX_OUTST, default 4: maximum outstanding memory requests.
REQ-004 SHALL have parameter RESET_PC, default 0: first fetch address.
REQ-005 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port pc_select_execute, input, 1: redirect request from execute.
REQ-008 SHALL have port pc_target_execute, input, XLEN: redirect target address.
REQ-009 SHALL have ports imem_req_valid (output, 1), imem_req_ready (input, 1) and imem_req_addr (output, XLEN): request channel.
REQ-010 SHALL have ports imem_rsp_valid (input, 1) and imem_rsp_data (input, XLEN): in-order response channel with no backpressure.
REQ-011 SHALL have ports instr_valid (output, 1) and instr_ready (input, 1): decode handshake.
REQ-012 SHALL have ports instruction_fetch, pc_fetch and next_pc_fetch (output, XLEN each): head-entry instruction, its PC, and that PC + 4.

Function
REQ-013 SHALL hold a request PC (req_pc) that is presented on imem_req_addr and advances by 4 on each accepted request (imem_req_valid && imem_req_ready).
- Wraps modulo 2^XLEN: 2^XLEN-4 goes to 0.
REQ-014 SHALL assert imem_req_valid only when all of the following hold:
- (queue count + outstanding) < DEPTH;
- outstanding < MAX_OUTST;
- pc_select_execute is low.
REQ-015 SHALL keep a FIFO of {pc, instr} entries.
- Non-discarded responses are written in arrival order, paired with the PC of the oldest outstanding request.
- The PC tracking FIFO depth is MAX_OUTST.
REQ-016 SHALL drive instr_valid = (count != 0), with instruction_fetch, pc_fetch and next_pc_fetch taken from the head entry.
- The head pops on instr_valid && instr_ready.
- Outputs are stable while instr_valid && !instr_ready.
REQ-017 SHALL give a latency of one cycle from response acceptance to instr_valid.
- No combinational path from imem_rsp to the decode outputs.
REQ-018 SHALL support push and pop in the same cycle when full: count is unchanged and no entry is lost.
REQ-019 SHALL handle a pc_select_execute cycle (redirect) as follows:
- flush the queue (count = 0);
- set req_pc = {pc_target_execute[XLEN-1:2], 2'b00};
- set discard = outstanding minus any response arriving that cycle;
- clear the PC tracking FIFO.
REQ-020 SHALL drop responses while discard != 0, decrementing discard by one per dropped response.
- Requests resume the cycle after the redirect; the credit check counts discard entries as outstanding.
REQ-021 SHALL give redirect priority over pop, push and request in the same cycle.
- instr_valid is forced low in the redirect cycle.
REQ-022 SHALL use a control FSM with states:
- RUN: normal;
- REDIR: one cycle after a redirect, no request issued;
- DRAIN: discard != 0, requests allowed.
- Transitions: RUN->REDIR on redirect; REDIR->DRAIN if discard != 0, else RUN; DRAIN->RUN when discard reaches 0; any state->REDIR on redirect.
REQ-023 SHALL flag responses arriving with outstanding = 0 and discard = 0 as protocol errors.
- These responses are ignored.
- An assertion fires in simulation only.

Reset
REQ-024 SHALL, while rst is high, set:
- req_pc = RESET_PC;
- count, outstanding and discard = 0;
- FSM = RUN;
- imem_req_valid = 0 and instr_valid = 0;
- instruction_fetch, pc_fetch and next_pc_fetch = 0.
REQ-025 SHALL abort in-flight requests on reset; responses arriving after reset deassertion without a matching post-reset request are handled per REQ-023.
REQ-026 SHALL assert the first request in the first cycle after rst deasserts.

Structure
REQ-027 SHALL place XLEN, RESET_PC default, the FSM state enum and the fetch-entry {pc, instr} typedef in the shared package fetch_pkg.
REQ-028 SHALL implement queue storage as sub-module fetch_fifo, with parameters WIDTH and DEPTH and ports push, pop, flush, full, empty and count.
- The PC tracking FIFO reuses the same sub-module.

Verification
REQ-029 SHALL cover a streaming case: imem_req_ready=1, 1-cycle response latency, instr_ready=1 -> pc_fetch sequence 0,4,8,... with one entry per cycle after fill.
REQ-030 SHALL cover backpressure: instr_ready=0 for 10 cycles -> count reaches DEPTH=4, imem_req_valid drops, and no instruction is lost or duplicated.
REQ-031 SHALL cover redirect with 3 requests outstanding to target 0x100 -> 3 responses dropped, next instr_valid carries pc_fetch=0x100 and next_pc_fetch=0x104.
REQ-032 SHALL cover redirect coinciding with a response and a pop -> the response is dropped, the queue is empty next cycle and discard=outstanding-1.
REQ-033 SHALL cover a misaligned target 0x203 -> first fetch address 0x200.
REQ-034 SHALL cover reset asserted mid-stream with 2 requests outstanding -> outputs are 0 immediately (asynchronously) and the first post-reset request goes to RESET_PC.
